// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg
// Shared control definitions for the LEGv8 PC sequencer:
//   - sequencer state codes (visible on the debug 'state' output)
//   - PC-select (PS) codes driven to the PC mux
//   - opcode match constants and the HLT encoding
//   - B.cond condition-code constants
//   - classify(): maps a 32-bit instruction word to its control class
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_UPDATE  = 3'd4,
        ST_HALT    = 3'd5
    } seq_state_t;

    // PC select: hold, PC+4, register target, PC+4+(in<<2)
    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_REG    = 2'b10;
    localparam logic [1:0] PS_BRANCH = 2'b11;

    // Opcode fields, matched against the top bits of the instruction
    localparam logic [5:0]  OPC_B     = 6'b000101;       // IR[31:26]
    localparam logic [10:0] OPC_BR    = 11'b11010110000; // IR[31:21]
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;     // IR[31:24]
    localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;     // IR[31:24]
    localparam logic [7:0]  OPC_BCOND = 8'b01010100;     // IR[31:24]
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010; // IR[31:21]
    localparam logic [10:0] OPC_STUR  = 11'b11111000000; // IR[31:21]
    localparam logic [31:0] INSTR_HLT = 32'hD4400000;

    // ARMv8 condition codes carried in IR[3:0] of B.cond
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_HS = 4'b0010;
    localparam logic [3:0] COND_LO = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef enum logic [3:0] {
        OP_SEQ,
        OP_B,
        OP_BR,
        OP_CBZ,
        OP_CBNZ,
        OP_BCOND,
        OP_LDUR,
        OP_STUR,
        OP_HLT
    } op_class_t;

    // HLT is an exact 32-bit match and is tested first so it can never be
    // shadowed by a field match.
    function automatic op_class_t classify(input logic [31:0] ir);
        op_class_t c;
        c = OP_SEQ;
        if (ir == INSTR_HLT)              c = OP_HLT;
        else if (ir[31:26] == OPC_B)      c = OP_B;
        else if (ir[31:21] == OPC_BR)     c = OP_BR;
        else if (ir[31:24] == OPC_CBZ)    c = OP_CBZ;
        else if (ir[31:24] == OPC_CBNZ)   c = OP_CBNZ;
        else if (ir[31:24] == OPC_BCOND)  c = OP_BCOND;
        else if (ir[31:21] == OPC_LDUR)   c = OP_LDUR;
        else if (ir[31:21] == OPC_STUR)   c = OP_STUR;
        return c;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval
// Combinational ARMv8 condition evaluator for B.cond.
// Ports:
//   cond  [3:0] in   condition code (IR[3:0])
//   flags [3:0] in   {N, Z, C, V}
//   taken       out  1 when the condition holds
module branch_cond_eval
    import legv8_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n_f, z_f, c_f, v_f;

    assign n_f = flags[3];
    assign z_f = flags[2];
    assign c_f = flags[1];
    assign v_f = flags[0];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z_f;
            COND_NE: taken = !z_f;
            COND_HS: taken = c_f;
            COND_LO: taken = !c_f;
            COND_MI: taken = n_f;
            COND_PL: taken = !n_f;
            COND_VS: taken = v_f;
            COND_VC: taken = !v_f;
            COND_HI: taken = c_f && !z_f;
            COND_LS: taken = !c_f || z_f;
            COND_GE: taken = (n_f == v_f);
            COND_LT: taken = (n_f != v_f);
            COND_GT: taken = !z_f && (n_f == v_f);
            COND_LE: taken = z_f || (n_f != v_f);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Multi-cycle LEGv8 control sequencer that decides, once per instruction,
// how the PC advances.
// Ports:
//   clock         in   sole clock, rising edge
//   reset         in   asynchronous, active-low
//   instr  [31:0] in   fetched instruction word
//   instr_valid   in   instr valid this cycle (latched only in FETCH)
//   mem_ready     in   data memory done (looked at only in MEM)
//   zero          in   ALU zero flag (sampled in EXECUTE)
//   status [3:0]  in   {N,Z,C,V} (sampled in EXECUTE)
//   stall         in   freeze request
//   PS     [1:0]  out  PC select; non-zero only in a non-stalled UPDATE
//   fetch_req     out  instruction request (FETCH, not stalled, out of reset)
//   branch_taken  out  pulse in UPDATE when PS is 10 or 11
//   halted        out  HALT reached
//   state  [2:0]  out  current state code for debug
//
// Handshake: an instruction is accepted in the cycle where fetch_req=1 and
// instr_valid=1 (fetch_req already folds in stall); mem_ready completes MEM
// in a cycle where stall=0. Everything else moves on the clock edge.
module pc_sequencer
    import legv8_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic [3:0]  status,
    input  logic        stall,
    output logic [1:0]  PS,
    output logic        fetch_req,
    output logic        branch_taken,
    output logic        halted,
    output logic [2:0]  state
);

    seq_state_t state_q, state_d;
    logic [31:0] ir_q;
    logic        ir_load;
    op_class_t   class_q;
    logic [1:0]  dec_q, dec_d;
    logic        run_q;       // 0 until the first edge after reset release
    logic        cond_taken;

    branch_cond_eval u_cond (
        .cond  (ir_q[3:0]),
        .flags (status),
        .taken (cond_taken)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            ir_q    <= 32'h0;
            class_q <= OP_SEQ;
            dec_q   <= PS_HOLD;
            run_q   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= instr;
            end
            if (state_q == ST_DECODE && !stall) begin
                class_q <= classify(ir_q);
            end
            if (state_q == ST_EXECUTE && !stall) begin
                dec_q <= dec_d;
            end
        end
    end

    // PC-select decision, registered at the end of EXECUTE so the flags
    // never reach PS directly.
    always_comb begin
        dec_d = PS_INC;
        case (class_q)
            OP_B:     dec_d = PS_BRANCH;
            OP_BR:    dec_d = PS_REG;
            OP_CBZ:   dec_d = zero ? PS_BRANCH : PS_INC;
            OP_CBNZ:  dec_d = zero ? PS_INC : PS_BRANCH;
            OP_BCOND: dec_d = cond_taken ? PS_BRANCH : PS_INC;
            default:  dec_d = PS_INC;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // stall wins over instr_valid; nothing is taken before the
                // first edge after reset, when fetch_req is still low
                if (run_q && instr_valid && !stall) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!stall) state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (!stall) begin
                    case (class_q)
                        OP_LDUR, OP_STUR: state_d = ST_MEM;
                        OP_HLT:           state_d = ST_HALT;
                        default:          state_d = ST_UPDATE;
                    endcase
                end
            end
            ST_MEM: begin
                if (!stall && mem_ready) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (!stall) state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // The PS value itself comes from dec_q; stall only acts as a force-to-
    // hold override so a frozen UPDATE cannot move the PC, and the single
    // pulse lands in the cycle where UPDATE actually completes.
    assign PS           = (state_q == ST_UPDATE && !stall) ? dec_q : PS_HOLD;
    assign branch_taken = (state_q == ST_UPDATE) && !stall && dec_q[1];
    assign fetch_req    = (state_q == ST_FETCH) && run_q && !stall;
    assign halted       = (state_q == ST_HALT);
    assign state        = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer. Expected PC-update pulses
// ({PS, branch_taken, state}) are queued by the stimulus; a monitor pops one
// entry each time the DUT shows a non-hold PS or a branch_taken pulse.
module tb_pc_sequencer;

    localparam int W = 6;

    localparam logic [31:0] I_SEQ   = 32'h8B020020;
    localparam logic [31:0] I_CBZ   = 32'hB4000040;
    localparam logic [31:0] I_CBNZ  = 32'hB5000040;
    localparam logic [31:0] I_BGT   = 32'h5400004C;
    localparam logic [31:0] I_BEQ   = 32'h54000040;
    localparam logic [31:0] I_BHI   = 32'h54000048;
    localparam logic [31:0] I_BLT   = 32'h5400004B;
    localparam logic [31:0] I_BAL   = 32'h5400004E;
    localparam logic [31:0] I_B     = 32'h14000010;
    localparam logic [31:0] I_BR    = 32'hD61F0000;
    localparam logic [31:0] I_LDUR  = 32'hF8400020;
    localparam logic [31:0] I_STUR  = 32'hF8000020;
    localparam logic [31:0] I_HLT   = 32'hD4400000;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_ready;
    logic        zero;
    logic [3:0]  status;
    logic        stall;
    logic [1:0]  PS;
    logic        fetch_req;
    logic        branch_taken;
    logic        halted;
    logic [2:0]  state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .mem_ready    (mem_ready),
        .zero         (zero),
        .status       (status),
        .stall        (stall),
        .PS           (PS),
        .fetch_req    (fetch_req),
        .branch_taken (branch_taken),
        .halted       (halted),
        .state        (state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_pulse(input logic [1:0] ps);
        logic [W-1:0] e;
        e = {ps, ps[1], 3'd4};
        exp_q.push_back(e);
    endtask

    // Presents ir in FETCH and walks to EXECUTE; flags stay as set here.
    task automatic fetch_decode(input logic [31:0] ir, input logic z, input logic [3:0] st);
        check("fetch_state", {29'd0, state}, 32'd0);
        check("fetch_req", {31'd0, fetch_req}, 32'd1);
        zero = z;
        status = st;
        instr = ir;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instr = 32'h0;
        check("decode_state", {29'd0, state}, 32'd1);
        check("decode_fetch_req", {31'd0, fetch_req}, 32'd0);
        step();
        check("execute_state", {29'd0, state}, 32'd2);
    endtask

    // Full non-memory instruction with a given required PS.
    task automatic do_branch(input logic [31:0] ir, input logic z, input logic [3:0] st,
                             input logic [1:0] exp_ps);
        fetch_decode(ir, z, st);
        push_pulse(exp_ps);
        step();
        check("update_state", {29'd0, state}, 32'd4);
        check("update_ps", {30'd0, PS}, {30'd0, exp_ps});
        // flags after EXECUTE must not change the registered decision
        zero = ~zero;
        status = ~status;
        #1;
        check("update_ps_flags_moved", {30'd0, PS}, {30'd0, exp_ps});
        step();
        check("back_to_fetch", {29'd0, state}, 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [W-1:0] got;
        logic [W-1:0] e;
        if (reset && (PS != 2'b00 || branch_taken)) begin
            got = {PS, branch_taken, state};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pc_pulse: got {ps,bt,state}=%b required no pulse", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL pc_pulse: got {ps,bt,state}=%b required %b", got, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        instr = 32'h0;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        zero = 1'b0;
        status = 4'h0;
        stall = 1'b0;

        // reset values, with inputs wiggling
        instr_valid = 1'b1;
        instr = I_B;
        step();
        step();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_ps", {30'd0, PS}, 32'd0);
        check("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("rst_branch_taken", {31'd0, branch_taken}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        instr_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rel_fetch_req_before_edge", {31'd0, fetch_req}, 32'd0);
        step();
        check("rel_fetch_req_after_edge", {31'd0, fetch_req}, 32'd1);

        // SEQ: FETCH, DECODE, EXECUTE, UPDATE with PS=01
        do_branch(I_SEQ, 1'b0, 4'h0, 2'b01);
        // CBZ / CBNZ both ways
        do_branch(I_CBZ,  1'b1, 4'h0, 2'b11);
        do_branch(I_CBZ,  1'b0, 4'h0, 2'b01);
        do_branch(I_CBNZ, 1'b0, 4'h0, 2'b11);
        do_branch(I_CBNZ, 1'b1, 4'h0, 2'b01);
        // B.cond
        do_branch(I_BGT, 1'b0, 4'b0000, 2'b11);
        do_branch(I_BGT, 1'b0, 4'b1000, 2'b01);
        do_branch(I_BEQ, 1'b0, 4'b0100, 2'b11);
        do_branch(I_BEQ, 1'b0, 4'b0000, 2'b01);
        do_branch(I_BHI, 1'b0, 4'b0010, 2'b11);
        do_branch(I_BHI, 1'b0, 4'b0110, 2'b01);
        do_branch(I_BLT, 1'b0, 4'b1000, 2'b11);
        do_branch(I_BLT, 1'b0, 4'b1001, 2'b01);
        do_branch(I_BAL, 1'b0, 4'b0000, 2'b11);
        // unconditional and register branches
        do_branch(I_B,  1'b0, 4'h0, 2'b11);
        do_branch(I_BR, 1'b0, 4'h0, 2'b10);

        // stall together with instr_valid in FETCH: not latched
        instr = I_HLT;
        instr_valid = 1'b1;
        stall = 1'b1;
        #1;
        check("fetch_stall_req", {31'd0, fetch_req}, 32'd0);
        step();
        check("fetch_stall_state", {29'd0, state}, 32'd0);
        stall = 1'b0;
        instr_valid = 1'b0;
        step();
        check("fetch_after_stall_state", {29'd0, state}, 32'd0);

        // stall in EXECUTE: zero sampled only on the non-stalled edge
        fetch_decode(I_CBZ, 1'b1, 4'h0);
        stall = 1'b1;
        zero = 1'b0;
        step();
        check("exec_stall_state", {29'd0, state}, 32'd2);
        step();
        check("exec_stall_state2", {29'd0, state}, 32'd2);
        stall = 1'b0;
        zero = 1'b1;
        push_pulse(2'b11);
        step();
        check("exec_stall_update_ps", {30'd0, PS}, 32'd3);
        step();

        // LDUR: mem_ready outside MEM ignored, 5 cycles in MEM, then UPDATE
        mem_ready = 1'b1;
        fetch_decode(I_LDUR, 1'b1, 4'hF);
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ldur_mem_state", {29'd0, state}, 32'd3);
            check("ldur_mem_ps", {30'd0, PS}, 32'd0);
            if (i < 4) step();
        end
        mem_ready = 1'b1;
        push_pulse(2'b01);
        step();
        mem_ready = 1'b0;
        check("ldur_update_state", {29'd0, state}, 32'd4);
        check("ldur_update_ps", {30'd0, PS}, 32'd1);
        step();

        // STUR with memory ready straight away
        fetch_decode(I_STUR, 1'b0, 4'h0);
        step();
        check("stur_mem_state", {29'd0, state}, 32'd3);
        mem_ready = 1'b1;
        push_pulse(2'b01);
        step();
        mem_ready = 1'b0;
        check("stur_update_ps", {30'd0, PS}, 32'd1);
        step();

        // B with 3 stalled UPDATE cycles, then one PS=11 cycle
        fetch_decode(I_B, 1'b0, 4'h0);
        push_pulse(2'b11);
        step();
        stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("upd_stall_state", {29'd0, state}, 32'd4);
            check("upd_stall_ps", {30'd0, PS}, 32'd0);
            check("upd_stall_bt", {31'd0, branch_taken}, 32'd0);
            if (i < 2) step();
        end
        step();
        stall = 1'b0;
        #1;
        check("upd_after_stall_ps", {30'd0, PS}, 32'd3);
        check("upd_after_stall_bt", {31'd0, branch_taken}, 32'd1);
        step();
        check("upd_after_stall_fetch", {29'd0, state}, 32'd0);

        // reset pulsed during MEM: abort, no pulse
        fetch_decode(I_LDUR, 1'b0, 4'h0);
        step();
        check("rmem_state", {29'd0, state}, 32'd3);
        step();
        reset = 1'b0;
        #1;
        check("rmem_state_async", {29'd0, state}, 32'd0);
        check("rmem_ps", {30'd0, PS}, 32'd0);
        check("rmem_fetch_req", {31'd0, fetch_req}, 32'd0);
        mem_ready = 1'b1;
        step();
        reset = 1'b1;
        #1;
        check("rmem_rel_fetch_req", {31'd0, fetch_req}, 32'd0);
        mem_ready = 1'b0;
        step();
        check("rmem_rel_fetch_req_edge", {31'd0, fetch_req}, 32'd1);
        check("rmem_rel_state", {29'd0, state}, 32'd0);

        // reset during a stalled UPDATE: abort, no pulse
        fetch_decode(I_B, 1'b0, 4'h0);
        step();
        stall = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("rupd_state", {29'd0, state}, 32'd0);
        check("rupd_ps", {30'd0, PS}, 32'd0);
        step();
        stall = 1'b0;
        reset = 1'b1;
        step();

        // SEQ after aborts still works
        do_branch(I_SEQ, 1'b1, 4'h5, 2'b01);

        // HLT: terminal, all inputs ignored
        fetch_decode(I_HLT, 1'b0, 4'h0);
        step();
        check("hlt_state", {29'd0, state}, 32'd5);
        check("hlt_halted", {31'd0, halted}, 32'd1);
        check("hlt_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("hlt_ps", {30'd0, PS}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            instr = I_B;
            instr_valid = 1'b1;
            mem_ready = 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            step();
            check("hlt_hold_state", {29'd0, state}, 32'd5);
            check("hlt_hold_ps", {30'd0, PS}, 32'd0);
        end
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        stall = 1'b0;
        reset = 1'b0;
        #1;
        check("hlt_reset_state", {29'd0, state}, 32'd0);
        check("hlt_reset_halted", {31'd0, halted}, 32'd0);
        step();
        reset = 1'b1;
        step();
        do_branch(I_CBZ, 1'b1, 4'h0, 2'b11);

        // ---------------- final report ----------------
        step();
        step();
        check("pending_pulses", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clock  input  1  sole clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- instr  input  32  fetched instruction word.
- instr_valid  input  1  instr is valid this cycle.
- mem_ready  input  1  data memory has completed the current LDUR/STUR.
- zero  input  1  ALU zero flag; used by CBZ/CBNZ.
- status  input  4  flags {N,Z,C,V}; used by B.cond.
- stall  input  1  freeze request from outside.
- PS  output  2  PC select: 00 hold, 01 PC+4, 10 in (register target), 11 PC+4+(in<<2).
- fetch_req  output  1  request for an instruction word.
- branch_taken  output  1  one-cycle pulse when a taken branch updates the PC.
- halted  output  1  HALT state reached.
- state  output  3  current state code, for debug.
REQ-002 The block SHALL have no parameters.

Function
REQ-003 The state machine SHALL have these states and codes: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, UPDATE=4, HALT=5.
REQ-004 FETCH SHALL assert fetch_req, and on instr_valid=1 with stall=0 SHALL latch instr into the internal IR and go to DECODE.
REQ-005 DECODE SHALL classify IR and go to EXECUTE after exactly one cycle.
REQ-006 Opcode classes SHALL be: B when IR[31:26]=000101; BR when IR[31:21]=11010110000; CBZ when IR[31:24]=10110100; CBNZ when IR[31:24]=10110101; B.cond when IR[31:24]=01010100; LDUR when IR[31:21]=11111000010; STUR when IR[31:21]=11111000000; HLT when IR=32'hD4400000; all other encodings are SEQ.
REQ-007 EXECUTE SHALL sample zero and status and register the PS decision, then go as follows: LDUR/STUR to MEM, HLT to HALT, all others to UPDATE.
REQ-008 The PS decision SHALL be: B -> 11; BR -> 10; CBZ -> 11 if zero=1, else 01; CBNZ -> 11 if zero=0, else 01; B.cond -> 11 if the condition holds, else 01; SEQ/LDUR/STUR -> 01.
REQ-009 The B.cond condition SHALL use IR[3:0] with the full ARMv8 set: EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE; codes 1110 and 1111 are always true.
REQ-010 MEM SHALL hold until mem_ready=1, then go to UPDATE; mem_ready outside MEM SHALL be ignored.
REQ-011 UPDATE SHALL drive PS to the registered decision for exactly one cycle and return to FETCH.
REQ-012 branch_taken SHALL pulse in the UPDATE cycle only when the decision is 10 or 11.
REQ-013 PS SHALL be 00 in every cycle other than a non-stalled UPDATE, so the PC advances exactly once per instruction.
REQ-014 stall=1 in any non-HALT state SHALL freeze the state and IR and force PS=00, fetch_req=0 and branch_taken=0; a stalled UPDATE SHALL complete on the first cycle with stall=0.
REQ-015 Simultaneous instr_valid and stall in FETCH: stall SHALL win and the instruction SHALL NOT be latched.
REQ-016 HALT SHALL be terminal until reset: PS=00, halted=1, fetch_req=0, and all inputs ignored.
REQ-017 Outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from any input to PS.

Reset
REQ-018 With reset=0 the block SHALL asynchronously enter FETCH with IR=0, PS=00, fetch_req=0, branch_taken=0, halted=0, state=0.
REQ-019 Reset asserted mid-instruction (including in MEM or UPDATE) SHALL abort the instruction with no PS pulse.
REQ-020 fetch_req SHALL assert on the first clock edge after reset is released.

Structure
REQ-021 A shared package legv8_ctrl_pkg SHALL hold the state codes, PS codes (PS_HOLD, PS_INC, PS_REG, PS_BRANCH), opcode match constants, the condition-code constants and the HLT encoding.
REQ-022 The B.cond evaluation SHALL be a combinational sub-module named branch_cond_eval, with inputs cond[3:0] and flags[3:0] and output taken.

Verification
REQ-023 SEQ instruction 32'h8B020020 with instr_valid=1 -> states FETCH, DECODE, EXECUTE, UPDATE; PS=01 for one cycle in cycle 4; branch_taken=0.
REQ-024 CBZ 32'hB4000040 with zero=1 -> PS=11 and branch_taken=1 in UPDATE; repeated with zero=0 -> PS=01 and branch_taken=0.
REQ-025 B.cond GT 32'h5400004C: status=4'b0000 -> PS=11; status=4'b1000 -> PS=01.
REQ-026 LDUR 32'hF8400020 with mem_ready held 0 for 5 cycles -> state=3 for 5 cycles with PS=00; mem_ready=1 -> UPDATE with PS=01.
REQ-027 stall=1 for 3 cycles during UPDATE of B 32'h14000010 -> PS=00 for those 3 cycles, then PS=11 for one cycle; reset=0 pulsed during MEM -> state=0, PS=00, no PS pulse.
REQ-028 HLT 32'hD4400000 -> halted=1 and PS=00 indefinitely, even with instr_valid=1; only reset recovers the block.
